// File: rtl/bullet_swarm.sv
// Multi-bullet motion engine: one bullet per clock, once per accepted frame tick.
// Optional speed ramp is compiled in with `define BULLET_RAMP_EN.
module bullet_swarm #(
  parameter int N           = 4,
  parameter int XW          = 11,
  parameter int YW          = 10,
  parameter int X0          = 200,
  parameter int Y0          = 500,
  parameter int X_STEP      = 120,
  parameter int X_MIN       = 2,
  parameter int X_MAX       = 762,
  parameter int Y_MIN       = 36,
  parameter int Y_MAX       = 562,
  parameter int VW          = 3,
  parameter int HIT_R       = 16,
  parameter int RAMP_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame,
  input  logic [XW-1:0]     player_x,
  input  logic [YW-1:0]     player_y,
  output logic [N*XW-1:0]   x,
  output logic [N*YW-1:0]   y,
  output logic              busy,
  output logic              over
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [XW:0] X_MIN_E = (XW+1)'(X_MIN);
  localparam logic [XW:0] X_MAX_E = (XW+1)'(X_MAX);
  localparam logic [YW:0] Y_MIN_E = (YW+1)'(Y_MIN);
  localparam logic [YW:0] Y_MAX_E = (YW+1)'(Y_MAX);

  if (N < 1 || N > 16 || RAMP_FRAMES < 1) begin : g_bad_param
    $error("bullet_swarm: N must be 1..16 and RAMP_FRAMES at least 1");
  end

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic            accept;

  logic [XW-1:0]   x_r [N];
  logic [YW-1:0]   y_r [N];
  logic [N-1:0]    dir_x, dir_y;

  logic [XW-1:0]   cur_x, x_new;
  logic [YW-1:0]   cur_y, y_new;
  logic            cur_dx, cur_dy, dx_new, dy_new;
  logic [VW-1:0]   cur_vx, cur_vy;
  logic [XW:0]     x_e, vx_e;
  logic [YW:0]     y_e, vy_e;
  logic [XW-1:0]   x_d;
  logic [YW-1:0]   y_d;
  logic            hit;

  assign accept = (state == IDLE) && frame && !over;

  // ---------------- FSM: state register / next state / outputs ----------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no branch leaves the signal unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = UPDATE;
      UPDATE:  if (idx == IW'(N-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // ---------------- Speed source ----------------
`ifdef BULLET_RAMP_EN
  localparam int            CW    = $clog2(RAMP_FRAMES + 1);
  localparam logic [VW-1:0] V_MAX = '1;

  logic [CW-1:0] ramp_cnt;
  logic [VW-1:0] v_x [N];
  logic [VW-1:0] v_y [N];

  // The bump is applied in DONE so the pass that hit the threshold keeps its old speeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_cnt <= '0;
      for (int i = 0; i < N; i++) begin
        v_x[i] <= VW'(2);
        v_y[i] <= VW'(3);
      end
    end else if (accept) begin
      ramp_cnt <= ramp_cnt + CW'(1);
    end else if (state == DONE && ramp_cnt == CW'(RAMP_FRAMES)) begin
      ramp_cnt <= '0;
      for (int i = 0; i < N; i++) begin
        if (v_x[i] != V_MAX) v_x[i] <= v_x[i] + VW'(1);
        if (v_y[i] != V_MAX) v_y[i] <= v_y[i] + VW'(1);
      end
    end
  end

  assign cur_vx = v_x[idx];
  assign cur_vy = v_y[idx];
`else
  assign cur_vx = VW'(2);
  assign cur_vy = VW'(3);
`endif

  // ---------------- Axis update and hit check for bullet[idx] ----------------
  assign cur_x  = x_r[idx];
  assign cur_y  = y_r[idx];
  assign cur_dx = dir_x[idx];
  assign cur_dy = dir_y[idx];

  always_comb begin
    x_new  = cur_x;
    y_new  = cur_y;
    dx_new = cur_dx;
    dy_new = cur_dy;
    x_e    = {1'b0, cur_x};
    y_e    = {1'b0, cur_y};
    vx_e   = (XW+1)'(cur_vx);
    vy_e   = (YW+1)'(cur_vy);

    // pos - v <= MIN is rewritten as pos <= MIN + v so nothing can underflow.
    if (!cur_dx) begin
      if (x_e <= X_MIN_E + vx_e) begin
        x_new  = XW'(X_MIN);
        dx_new = 1'b1;
      end else begin
        x_new = XW'(x_e - vx_e);
      end
    end else begin
      if (x_e + vx_e >= X_MAX_E) begin
        x_new  = XW'(X_MAX);
        dx_new = 1'b0;
      end else begin
        x_new = XW'(x_e + vx_e);
      end
    end

    if (!cur_dy) begin
      if (y_e <= Y_MIN_E + vy_e) begin
        y_new  = YW'(Y_MIN);
        dy_new = 1'b1;
      end else begin
        y_new = YW'(y_e - vy_e);
      end
    end else begin
      if (y_e + vy_e >= Y_MAX_E) begin
        y_new  = YW'(Y_MAX);
        dy_new = 1'b0;
      end else begin
        y_new = YW'(y_e + vy_e);
      end
    end

    x_d = (x_new >= player_x) ? (x_new - player_x) : (player_x - x_new);
    y_d = (y_new >= player_y) ? (y_new - player_y) : (player_y - y_new);
    hit = (x_d < XW'(HIT_R)) && (y_d < YW'(HIT_R));
  end

  // ---------------- Bullet state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      over <= 1'b0;
      // NOTE: this is a flop array, not a RAM: every entry has its own reset value.
      for (int i = 0; i < N; i++) begin
        x_r[i]   <= XW'(X0 + i * X_STEP);
        y_r[i]   <= YW'(Y0);
        dir_x[i] <= 1'(i % 2);
        dir_y[i] <= 1'b0;
      end
    end else if (accept) begin
      idx <= '0;
    end else if (state == UPDATE) begin
      idx        <= idx + IW'(1);
      x_r[idx]   <= x_new;
      y_r[idx]   <= y_new;
      dir_x[idx] <= dx_new;
      dir_y[idx] <= dy_new;
      if (hit) over <= 1'b1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign x[g*XW +: XW] = x_r[g];
    assign y[g*YW +: YW] = y_r[g];
  end

endmodule

// File: tb/tb_bullet_swarm.sv
// Self-checking bench for bullet_swarm: frame-level behavioural model plus
// directed pins (reset, first pass, bounces, hit, drops) and a random run.
module tb_bullet_swarm;

  localparam int N = 4, XW = 11, YW = 10;
  localparam int X_MIN = 2, X_MAX = 762, Y_MIN = 36, Y_MAX = 562;
  localparam int HIT_R = 16, RAMP_FRAMES = 8, V_MAX = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame = 1'b0;
  logic [XW-1:0]   player_x = '0;
  logic [YW-1:0]   player_y = '0;
  logic [N*XW-1:0] x;
  logic [N*YW-1:0] y;
  logic            busy, over;

  bullet_swarm dut (
    .clk(clk), .rst(rst), .frame(frame),
    .player_x(player_x), .player_y(player_y),
    .x(x), .y(y), .busy(busy), .over(over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;

  // Model: bullet state plus "cycles since the frame was accepted" (0 = idle).
  int m_x [N], m_y [N], m_dx [N], m_dy [N], m_vx [N], m_vy [N];
  int m_over, m_k, m_cnt, m_accepted;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int dut_x(input int i);
    return int'(x[i*XW +: XW]);
  endfunction

  function automatic int dut_y(input int i);
    return int'(y[i*YW +: YW]);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 200 + 120 * i;  m_y[i] = 500;
      m_dx[i] = i % 2;         m_dy[i] = 0;
      m_vx[i] = 2;             m_vy[i] = 3;
    end
    m_over = 0; m_k = 0; m_cnt = 0;
  endtask

  task automatic move(inout int p, inout int d, input int v, input int lo, input int hi);
    if (d == 0) begin
      if (p - v <= lo) begin p = lo; d = 1; end
      else p = p - v;
    end else begin
      if (p + v >= hi) begin p = hi; d = 0; end
      else p = p + v;
    end
  endtask

  // What one rising edge does, given the inputs presented to it.
  task automatic model_step(input bit f, input int px, input int py);
    if (m_k == 0) begin
      if (f && m_over == 0) begin
        m_k = 1; m_accepted++; m_cnt++;
      end
    end else if (m_k <= N) begin
      int b;
      b = m_k - 1;
      move(m_x[b], m_dx[b], m_vx[b], X_MIN, X_MAX);
      move(m_y[b], m_dy[b], m_vy[b], Y_MIN, Y_MAX);
      if (iabs(m_x[b] - px) < HIT_R && iabs(m_y[b] - py) < HIT_R) m_over = 1;
      m_k++;
    end else begin
      m_k = 0;
`ifdef BULLET_RAMP_EN
      if (m_cnt == RAMP_FRAMES) begin
        m_cnt = 0;
        for (int i = 0; i < N; i++) begin
          if (m_vx[i] < V_MAX) m_vx[i]++;
          if (m_vy[i] < V_MAX) m_vy[i]++;
        end
      end
`endif
    end
  endtask

  task automatic compare();
    check("busy", int'(busy), (m_k != 0) ? 1 : 0);
    check("over", int'(over), m_over);
    for (int i = 0; i < N; i++) begin
      check($sformatf("x%0d", i), dut_x(i), m_x[i]);
      check($sformatf("y%0d", i), dut_y(i), m_y[i]);
    end
    if (busy) busy_cnt++;
  endtask

  // Called at a falling edge: drive inputs, let one rising edge happen, compare.
  task automatic cycle(input bit f, input int px, input int py);
    frame = f;
    player_x = XW'(px);
    player_y = YW'(py);
    @(posedge clk);
    model_step(f, px, py);
    @(negedge clk);
    compare();
  endtask

  task automatic run_frame(input int px, input int py);
    cycle(1'b1, px, py);
    repeat (N + 1) cycle(1'b0, px, py);
  endtask

  // Asynchronous reset placed between edges; its effect must be visible immediately.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 compare();
    @(negedge clk);
    compare();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    m_accepted = 0;
    @(negedge clk);
    compare();
    check("rst_x0", dut_x(0), 200);
    check("rst_x3", dut_x(3), 560);
    check("rst_y2", dut_y(2), 500);
    rst = 1'b0;

    // First pass, player far away: bullet 0 left/up, bullet 1 right/up, busy N+1 cycles.
    busy_cnt = 0;
    cycle(1'b1, 0, 0);
    repeat (8) cycle(1'b0, 0, 0);
    check("busy_len", busy_cnt, 5);
    check("p1_x0", dut_x(0), 198);
    check("p1_y0", dut_y(0), 497);
    check("p1_x1", dut_x(1), 322);
    check("p1_y1", dut_y(1), 497);

    // Left wall: 4 - 2 lands exactly on X_MIN at frame 99, then moves right.
    repeat (98) run_frame(0, 0);
    check("xmin_clamp", dut_x(0), 2);
    run_frame(0, 0);
    check("xmin_after", dut_x(0), 4);
    check("y0_f100", dut_y(0), 200);

    // Top wall: 38 - 3 overshoots Y_MIN at frame 155, clamps to 36, then 39.
    repeat (55) run_frame(0, 0);
    check("ymin_clamp", dut_y(0), 36);
    run_frame(0, 0);
    check("ymin_after", dut_y(0), 39);

    // Hit on bullet 0; over two cycles after frame, rest of pass continues, later frames ignored.
    do_reset();
    cycle(1'b1, 198, 497);
    check("hit_t1", int'(over), 0);
    cycle(1'b0, 198, 497);
    check("hit_t2", int'(over), 1);
    repeat (6) cycle(1'b0, 198, 497);
    check("hit_x3", dut_x(3), 562);
    check("hit_y3", dut_y(3), 497);
    busy_cnt = 0;
    run_frame(0, 0);
    check("ignored_busy", busy_cnt, 0);
    check("ignored_x0", dut_x(0), 198);

    // Mid-pass reset abandons the pass.
    do_reset();
    cycle(1'b1, 0, 0);
    cycle(1'b0, 0, 0);
    cycle(1'b0, 0, 0);
    do_reset();
    check("midrst_x0", dut_x(0), 200);
    repeat (4) cycle(1'b0, 0, 0);
    check("midrst_busy", int'(busy), 0);

    // Frame pulses every 2 cycles: only one in three is accepted.
    m_accepted = 0;
    for (int c = 0; c < 30; c++) cycle((c % 2) == 0, 0, 0);
    repeat (8) cycle(1'b0, 0, 0);
    check("drop_accepted", m_accepted, 5);
    check("drop_x0", dut_x(0), 190);

    // Random traffic: frames, player sometimes near a bullet, occasional resets.
    for (int c = 0; c < 4000; c++) begin
      int px, py, j;
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) begin
        j  = $urandom_range(0, N - 1);
        px = m_x[j] + $urandom_range(0, 40) - 20;
        py = m_y[j] + $urandom_range(0, 40) - 20;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end else begin
        px = $urandom_range(0, 2047);
        py = $urandom_range(0, 1023);
        if ($urandom_range(0, 1) == 0) begin px = 0; py = 0; end
      end
      cycle($urandom_range(0, 3) == 0, px, py);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
